// File: rtl/gpio_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_pkg
// Description : Shared types and constants for the GPIO interrupt detector.
//               irq_type_e encodes the per-channel event mode; gpio_irq_id_w
//               sizes the optional channel-ID output (GPIO_IRQ_ID_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_RISE  = 2'b00,
    IRQ_FALL  = 2'b01,
    IRQ_ANY   = 2'b10,
    IRQ_LEVEL = 2'b11
  } irq_type_e;

  localparam int GPIO_IRQ_MAX_CH = 32;

  // Width of a channel index, never narrower than one bit.
  function automatic int gpio_irq_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_irq_chan.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_chan
// Description : One GPIO interrupt channel: pad synchroniser, debounce
//               filter, edge/level detector, sticky pending and overflow.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_pad           - asynchronous pad input
//               i_en            - interrupt enable
//               i_type          - event mode (irq_type_e encoding)
//               i_debounce      - debounce threshold D in cycles
//               i_clr           - clear pending/overflow
//               o_pending       - sticky pending bit
//               o_overflow      - sticky overflow bit
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_chan
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pad,
  input  logic                  i_en,
  input  logic [1:0]            i_type,
  input  logic [DEBOUNCE_W-1:0] i_debounce,
  input  logic                  i_clr,
  output logic                  o_pending,
  output logic                  o_overflow
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DEBOUNCE_W-1:0]  r_cnt;
  logic                   r_filt;
  logic                   r_filt_q;
  logic                   r_pending;
  logic                   r_overflow;

  logic                   w_sync;
  logic                   w_det;
  logic                   w_event;
  irq_type_e              w_type;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_type = irq_type_e'(i_type);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
    end
  end

  // The filter only follows sync after D+1 consecutive disagreeing cycles;
  // the counter parks at all-ones rather than wrapping back to a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_filt   <= 1'b0;
      r_filt_q <= 1'b0;
    end else begin
      r_filt_q <= r_filt;
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == i_debounce) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else if (r_cnt != {DEBOUNCE_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_det = 1'b0;
    case (w_type)
      IRQ_RISE:  w_det = r_filt & ~r_filt_q;
      IRQ_FALL:  w_det = ~r_filt & r_filt_q;
      IRQ_ANY:   w_det = r_filt ^ r_filt_q;
      IRQ_LEVEL: w_det = r_filt;
      default:   w_det = 1'b0;
    endcase
  end

  assign w_event = w_det & i_en;

  // Set has priority over clear so a coincident event is never lost.
  // Level mode re-fires every cycle, so it is not counted as an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_event) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
      if (w_event && r_pending && (w_type != IRQ_LEVEL)) begin
        r_overflow <= 1'b1;
      end else if (i_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/gpio_irq_detect.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_detect
// Description : NUM_CH-channel GPIO interrupt detector with per-channel
//               mode, debounce, sticky pending/overflow and one registered
//               interrupt line. Optional macro GPIO_IRQ_ID_EN adds a
//               registered lowest-index pending channel ID.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               gpio_in           - asynchronous pad inputs
//               cfg_en_i          - per-channel enable
//               cfg_type_i        - 2-bit mode per channel
//               cfg_debounce_i    - global debounce threshold
//               clr_valid_i       - clear strobe
//               clr_mask_i        - channels to clear
//               pending_o         - sticky pending bits
//               overflow_o        - sticky overflow bits
//               irq_o             - registered OR of enabled pending bits
//               irq_id_o          - (GPIO_IRQ_ID_EN) lowest active channel
//               irq_id_valid_o    - (GPIO_IRQ_ID_EN) equals irq_o
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_detect
  import gpio_irq_pkg::*;
#(
  parameter int NUM_CH      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     gpio_in,
  input  logic [NUM_CH-1:0]     cfg_en_i,
  input  logic [2*NUM_CH-1:0]   cfg_type_i,
  input  logic [DEBOUNCE_W-1:0] cfg_debounce_i,
  input  logic                  clr_valid_i,
  input  logic [NUM_CH-1:0]     clr_mask_i,
  output logic [NUM_CH-1:0]     pending_o,
  output logic [NUM_CH-1:0]     overflow_o,
  output logic                  irq_o
`ifdef GPIO_IRQ_ID_EN
  ,
  output logic [gpio_irq_id_w(NUM_CH)-1:0] irq_id_o,
  output logic                             irq_id_valid_o
`endif
);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_overflow;
  logic [NUM_CH-1:0] w_active;
  logic              r_irq;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gpio_irq_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_pad      (gpio_in[c]),
      .i_en       (cfg_en_i[c]),
      .i_type     (cfg_type_i[2*c +: 2]),
      .i_debounce (cfg_debounce_i),
      .i_clr      (clr_valid_i & clr_mask_i[c]),
      .o_pending  (w_pending[c]),
      .o_overflow (w_overflow[c])
    );
  end

  // Disabled channels keep their pending state but cannot raise the line.
  assign w_active = w_pending & cfg_en_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_active;
    end
  end

  assign pending_o  = w_pending;
  assign overflow_o = w_overflow;
  assign irq_o      = r_irq;

`ifdef GPIO_IRQ_ID_EN
  localparam int c_ID_W = gpio_irq_id_w(NUM_CH);

  logic [c_ID_W-1:0] w_id;
  logic [c_ID_W-1:0] r_id;

  // Scan high to low so the lowest active index is written last and wins.
  always_comb begin
    w_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_id = c_ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id <= '0;
    end else begin
      r_id <= w_id;
    end
  end

  assign irq_id_o       = r_id;
  assign irq_id_valid_o = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_irq_detect
// Description : Self-checking bench for gpio_irq_detect (NUM_CH=32,
//               SYNC_STAGES=2, DEBOUNCE_W=8). Table of directed vectors
//               plus hand-written multi-cycle sequences. Optional checks
//               for GPIO_IRQ_ID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_detect;

  logic        clk;
  logic        rst;
  logic [31:0] gpio;
  logic [31:0] en;
  logic [63:0] typ;
  logic [7:0]  deb;
  logic        clr_v;
  logic [31:0] clr_m;
  logic [31:0] pend;
  logic [31:0] ovf;
  logic        irq;
`ifdef GPIO_IRQ_ID_EN
  logic [4:0]  irq_id;
  logic        irq_id_v;
`endif

  int n_checks;
  int n_fail;

  gpio_irq_detect #(
    .NUM_CH      (32),
    .SYNC_STAGES (2),
    .DEBOUNCE_W  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gpio_in        (gpio),
    .cfg_en_i       (en),
    .cfg_type_i     (typ),
    .cfg_debounce_i (deb),
    .clr_valid_i    (clr_v),
    .clr_mask_i     (clr_m),
    .pending_o      (pend),
    .overflow_o     (ovf),
    .irq_o          (irq)
`ifdef GPIO_IRQ_ID_EN
    ,
    .irq_id_o       (irq_id),
    .irq_id_valid_o (irq_id_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] gpio;
    logic [31:0] en;
    logic [63:0] typ;
    logic [31:0] clr;
    int          ncyc;
    logic [31:0] ep;
    logic [31:0] eo;
    logic        ei;
  } vec_t;

  vec_t tbl[12];

  // Advance n clock edges; outputs are stable 1 ns after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    gpio  = '0;
    en    = '0;
    typ   = '0;
    deb   = '0;
    clr_v = 1'b0;
    clr_m = '0;

    //            gpio          en            typ            clr           n  pend          ovf           irq
    tbl[0]  = '{32'h0000_0004, 32'h0000_0004, 64'h0,   32'h0,        3, 32'h0,        32'h0, 1'b0};
    tbl[1]  = '{32'h0000_0004, 32'h0000_0004, 64'h0,   32'h0,        1, 32'h4,        32'h0, 1'b0};
    tbl[2]  = '{32'h0000_0004, 32'h0000_0004, 64'h0,   32'h0,        1, 32'h4,        32'h0, 1'b1};
    tbl[3]  = '{32'h0000_0004, 32'h0000_0004, 64'h0,   32'h4,        1, 32'h0,        32'h0, 1'b1};
    tbl[4]  = '{32'h0000_0004, 32'h0000_0004, 64'h0,   32'h0,        1, 32'h0,        32'h0, 1'b0};
    tbl[5]  = '{32'h0000_0006, 32'h0000_0006, 64'h8,   32'h0,        4, 32'h2,        32'h0, 1'b0};
    tbl[6]  = '{32'h0000_0004, 32'h0000_0006, 64'h8,   32'h0,        4, 32'h2,        32'h2, 1'b1};
    tbl[7]  = '{32'h0000_0004, 32'h0000_0006, 64'h8,   32'h2,        2, 32'h0,        32'h0, 1'b0};
    tbl[8]  = '{32'h0000_0014, 32'h0000_0016, 64'h108, 32'h0,        5, 32'h0,        32'h0, 1'b0};
    tbl[9]  = '{32'h0000_0004, 32'h0000_0016, 64'h108, 32'h0,        5, 32'h10,       32'h0, 1'b1};
    tbl[10] = '{32'h0000_0004, 32'h0000_0016, 64'h108, 32'h10,       2, 32'h0,        32'h0, 1'b0};
    tbl[11] = '{32'h0000_0044, 32'h0000_0016, 64'h108, 32'h0,        5, 32'h0,        32'h0, 1'b0};

    // Reset state
    tick(2);
    rst = 1'b0;
    chk("reset_pending", 64'(pend), 64'h0);
    chk("reset_overflow", 64'(ovf), 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);

    // Table: rise + clear, any-edge overflow, fall mode, disabled channel
    for (int i = 0; i < 12; i++) begin
      gpio = tbl[i].gpio;
      en   = tbl[i].en;
      typ  = tbl[i].typ;
      if (tbl[i].clr != 32'h0) begin
        clr_v = 1'b1;
        clr_m = tbl[i].clr;
      end
      tick(1);
      clr_v = 1'b0;
      clr_m = '0;
      tick(tbl[i].ncyc - 1);
      chk($sformatf("vec%0d_pending", i), 64'(pend), 64'(tbl[i].ep));
      chk($sformatf("vec%0d_overflow", i), 64'(ovf), 64'(tbl[i].eo));
      chk($sformatf("vec%0d_irq", i), 64'(irq), 64'(tbl[i].ei));
    end

    // Debounce D=5 on ch0: 5-cycle glitch rejected, held input lands at E8
    en  = 32'h17;
    deb = 8'd5;
    gpio[0] = 1'b1;
    tick(5);
    gpio[0] = 1'b0;
    tick(10);
    chk("deb_glitch_pending", 64'(pend), 64'h0);
    gpio[0] = 1'b1;
    tick(8);
    chk("deb_e7_pending0", 64'(pend[0]), 64'h0);
    tick(1);
    chk("deb_e8_pending0", 64'(pend[0]), 64'h1);
    gpio[0] = 1'b0;
    tick(10);
    deb   = 8'd0;
    clr_v = 1'b1;
    clr_m = 32'h1;
    tick(1);
    clr_v = 1'b0;
    clr_m = '0;
    tick(4);
    chk("deb_cleanup_pending", 64'(pend), 64'h0);

    // Any-edge overflow, then clear colliding with a third edge
    gpio[1] = 1'b1;
    tick(4);
    chk("ovf_first_pending", 64'(pend), 64'h2);
    gpio[1] = 1'b0;
    tick(4);
    chk("ovf_second_overflow", 64'(ovf), 64'h2);
    gpio[1] = 1'b1;
    tick(3);
    clr_v = 1'b1;
    clr_m = 32'h2;
    tick(1);
    clr_v = 1'b0;
    clr_m = '0;
    chk("collide_pending", 64'(pend[1]), 64'h1);
    chk("collide_overflow", 64'(ovf[1]), 64'h1);
    clr_v = 1'b1;
    clr_m = 32'h2;
    tick(1);
    clr_v = 1'b0;
    clr_m = '0;
    chk("clr_after_collide_pending", 64'(pend[1]), 64'h0);
    chk("clr_after_collide_overflow", 64'(ovf[1]), 64'h0);

    // Level-high on ch3: clear ineffective while high
    typ = 64'h1C8;
    en  = 32'h1F;
    gpio[3] = 1'b1;
    tick(4);
    chk("level_set_pending", 64'(pend[3]), 64'h1);
    clr_v = 1'b1;
    clr_m = 32'h8;
    tick(1);
    clr_v = 1'b0;
    clr_m = '0;
    chk("level_clr_held_pending", 64'(pend[3]), 64'h1);
    chk("level_no_overflow", 64'(ovf[3]), 64'h0);
    gpio[3] = 1'b0;
    tick(4);
    clr_v = 1'b1;
    clr_m = 32'h8;
    tick(1);
    clr_v = 1'b0;
    clr_m = '0;
    chk("level_clr_low_pending", 64'(pend[3]), 64'h0);

    // Masking on ch5
    en = 32'h3F;
    gpio[5] = 1'b1;
    tick(5);
    chk("mask_pending5", 64'(pend[5]), 64'h1);
    chk("mask_irq_on", 64'(irq), 64'h1);
    en[5] = 1'b0;
    tick(2);
    chk("mask_irq_off", 64'(irq), 64'h0);
    chk("mask_pending5_kept", 64'(pend[5]), 64'h1);

    // Reset in the middle of a debounce count
    deb = 8'd5;
    gpio[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_pending", 64'(pend), 64'h0);
    chk("midrst_overflow", 64'(ovf), 64'h0);
    chk("midrst_irq", 64'(irq), 64'h0);
    tick(1);
    rst = 1'b0;
    tick(12);
    chk("post_rst_rise_pending0", 64'(pend[0]), 64'h1);
    chk("post_rst_disabled_pending5", 64'(pend[5]), 64'h0);

`ifdef GPIO_IRQ_ID_EN
    // Lowest-index channel ID
    deb  = 8'd0;
    gpio = '0;
    typ  = '0;
    en   = '0;
    rst  = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("id_reset", 64'(irq_id), 64'h0);
    en   = 32'h0000_1080;
    gpio = 32'h0000_1080;
    tick(5);
    chk("id_lowest", 64'(irq_id), 64'd7);
    chk("id_valid", 64'(irq_id_v), 64'h1);
    clr_v = 1'b1;
    clr_m = 32'h80;
    tick(1);
    clr_v = 1'b0;
    clr_m = '0;
    tick(1);
    chk("id_after_clr", 64'(irq_id), 64'd12);
    chk("id_valid_after_clr", 64'(irq_id_v), 64'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_irq_detect.md
Name: gpio_irq_detect

Overview:
- Parametrised GPIO interrupt detector for the peripheral subsystem.
- Synchronises and debounces NUM_CH asynchronous pad inputs, then detects a per-channel event type: rise, fall, any edge or level-high.
- Latches events into sticky pending bits and drives one registered interrupt line towards the event unit.
- Generalises the single-pin, rise-only GPIO interrupt path to N channels with configurable modes, a debounce filter and overflow tracking.

Parameters:
- NUM_CH, 32: number of GPIO channels (1..32).
- SYNC_STAGES, 2: synchroniser depth (>=2).
- DEBOUNCE_W, 8: width of the debounce threshold and of each per-channel counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- gpio_in  in  NUM_CH  asynchronous pad inputs.
- cfg_en_i  in  NUM_CH  per-channel interrupt enable.
- cfg_type_i  in  2*NUM_CH  per-channel mode; channel c uses bits [2c+1:2c]. 00 rise, 01 fall, 10 any edge, 11 level-high.
- cfg_debounce_i  in  DEBOUNCE_W  global debounce threshold D, in cycles.
- clr_valid_i  in  1  clear strobe.
- clr_mask_i  in  NUM_CH  channels to clear when clr_valid_i=1.
- pending_o  out  NUM_CH  sticky pending bits.
- overflow_o  out  NUM_CH  sticky overflow: an event arrived while the channel was already pending.
- irq_o  out  1  registered OR of (pending & cfg_en_i).

Behaviour:
- Reset (rst=1 at a rising clk edge): all sync flops, filtered, filtered_q, counters, pending_o, overflow_o and irq_o go to 0. Reset mid-operation discards all state, including in-flight debounce counts.
- An input held high through reset is seen as a 0->1 transition after reset. A channel configured for rise or any-edge therefore raises an event.
- Synchroniser: SYNC_STAGES-flop chain per channel. sync = last stage.
- Debounce, per channel:
  - sync == filtered: counter is cleared to 0.
  - sync != filtered and counter == D: filtered <= sync, counter <= 0.
  - Otherwise counter increments. It saturates at all-ones and never wraps.
  - D=0 means filtered follows sync with one cycle of latency.
  - A glitch shorter than D+1 cycles at sync never reaches filtered.
- Event detection (filtered_q = filtered delayed by one cycle):
  - rise: filtered & ~filtered_q.
  - fall: ~filtered & filtered_q.
  - any edge: filtered ^ filtered_q.
  - level-high: filtered, every cycle.
  - An event counts only when cfg_en_i[c]=1.
- Pending bit:
  - Set on an event; cleared when clr_valid_i & clr_mask_i[c].
  - Event and clear in the same cycle: set wins, so the event is never lost.
  - Level-high mode re-sets pending every cycle while the input is high, so a clear has no effect until the input drops.
- Overflow bit:
  - Set when an event occurs while pending[c]=1 already, excluding level-high mode.
  - Cleared by the same clear strobe; set wins on a simultaneous event and clear.
- Disabling a channel (cfg_en_i[c]=0) blocks new events. pending[c] is kept but masked from irq_o.
- Latency, with E0 = the first clk edge that samples the new gpio_in value:
  - filtered updates at E(SYNC_STAGES+D).
  - pending_o sets at E(SYNC_STAGES+D+1).
  - irq_o asserts at E(SYNC_STAGES+D+2).
  - irq_o deasserts one edge after the last enabled pending bit clears.
- Changing cfg_type_i takes effect from the next cycle. No event is synthesised by the mode change itself.

Optional Feature:
- Macro: GPIO_IRQ_ID_EN.
- Defined: adds irq_id_o (out, $clog2(NUM_CH) bits, minimum 1) and irq_id_valid_o (out, 1).
  - Both are registered and updated alongside irq_o.
  - irq_id_o = lowest-index channel with pending & cfg_en_i; irq_id_valid_o = irq_o.
  - Both reset to 0.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package gpio_irq_pkg holds:
  - typedef enum logic [1:0] irq_type_e {IRQ_RISE, IRQ_FALL, IRQ_ANY, IRQ_LEVEL};
  - localparam GPIO_IRQ_MAX_CH = 32.
- One sub-module, gpio_irq_chan: a single channel's synchroniser, debounce, edge detector, pending and overflow logic, generated NUM_CH times.
- The top level holds clear fan-out, irq_o, and the optional ID priority encoder.

Test Plan:
- Rise: ch2 enabled, type 00, D=0, gpio_in[2] 0->1 -> pending_o=32'h4 at E3, irq_o=1 at E4. Clear with clr_mask=32'h4 -> pending 0 and irq_o 0 one edge later.
- Debounce: D=5, 4-cycle high pulse on ch0 -> no event. 8-cycle pulse -> pending[0] at E8 after sampling.
- Overflow and collision: ch1 in any-edge mode toggles twice without a clear -> overflow_o[1]=1. Clear in the same cycle as a third edge -> pending[1] stays 1 and overflow[1] stays 1.
- Level: ch3 type 11 held high while clearing -> pending[3] stays 1. Drop the input, then clear -> 0.
- Masking and reset: pending ch5, cfg_en[5]=0 -> irq_o=0 with pending_o[5]=1. Assert rst mid-debounce -> all outputs 0 the next edge.
- GPIO_IRQ_ID_EN: ch7 and ch12 pending -> irq_id_o=7. Clear ch7 -> irq_id_o=12.
